// File: rtl/rf_ctx_pkg.sv
// Shared types and constants for the register-file context-save controller.
// The register-file addresses name the working set that a push saves and clears.
package rf_ctx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUSH   = 3'd1,
    POP_RD = 3'd2,
    POP_WR = 3'd3,
    FAULT  = 3'd4
  } ctx_state_e;

  localparam int RF_ACC_ADDR      = 2;
  localparam int RF_WORK_FIRST    = 3;
  localparam int RF_WORK_LAST     = 10;
  localparam int DEFAULT_DEPTH    = 16;
  localparam int DEFAULT_PC_WIDTH = 5;

endpackage

// File: rtl/rf_ctx_ctrl_if.sv
// Decoder-side request/response bundle of the context-save controller.
// The decoder is the master; the controller is the slave.
interface rf_ctx_ctrl_if
  import rf_ctx_pkg::*;
#(
  parameter int PC_WIDTH = DEFAULT_PC_WIDTH
);

  logic                call_req;
  logic [PC_WIDTH-1:0] call_ret_pc;
  logic                ret_req;
  logic                req_ready;
  logic                done;
  logic [PC_WIDTH-1:0] ret_pc;
  logic                ret_pc_valid;

  modport master (
    output call_req, call_ret_pc, ret_req,
    input  req_ready, done, ret_pc, ret_pc_valid
  );

  modport slave (
    input  call_req, call_ret_pc, ret_req,
    output req_ready, done, ret_pc, ret_pc_valid
  );

endinterface

// File: rtl/rf_ctx_ret_lifo.sv
// Return-address store: DEPTH flops of PC_WIDTH bits, indexed write, combinational read.
// Unreset on purpose; entries at or above the current depth are don't-care.
module rf_ctx_ret_lifo
  import rf_ctx_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int PC_WIDTH = DEFAULT_PC_WIDTH
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [PC_WIDTH-1:0] wr_idx,
  input  logic [PC_WIDTH-1:0] wr_data,
  input  logic [PC_WIDTH-1:0] rd_idx,
  output logic [PC_WIDTH-1:0] rd_data
);

  logic [PC_WIDTH-1:0] mem_q [DEPTH];
  logic [PC_WIDTH-1:0] mem_d [DEPTH];

  // Index compares rather than direct array selects keep the index port a fixed width.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_idx == PC_WIDTH'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == PC_WIDTH'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/rf_ctx_ctrl.sv
// Context-save controller: sequences register-file push/pop for CALL/RET,
// tracks nesting depth and keeps sticky overflow/underflow flags.
module rf_ctx_ctrl
  import rf_ctx_pkg::*;
#(
  parameter int PC_WIDTH = DEFAULT_PC_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  rf_ctx_ctrl_if.slave                 dec,
  input  logic                         err_clr,
  output logic                         rf_stack_push,
  output logic                         rf_stack_pop,
  output logic [PC_WIDTH-1:0]          rf_stack_pointer,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         err_ovf,
  output logic                         err_udf
);

  localparam int SPW = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > (2 ** PC_WIDTH) - 1) begin : g_depth_check
    $error("rf_ctx_ctrl: DEPTH must lie in 1..2**PC_WIDTH-1");
  end

  ctx_state_e          state_q, state_d;
  logic [SPW-1:0]      sp_q, sp_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_udf_q, err_udf_d;
  logic                lifo_we;
  logic [PC_WIDTH-1:0] lifo_rd_data;

  rf_ctx_ret_lifo #(
    .DEPTH    (DEPTH),
    .PC_WIDTH (PC_WIDTH)
  ) u_ret_lifo (
    .clk     (clk),
    .wr_en   (lifo_we),
    .wr_idx  (PC_WIDTH'(sp_q)),
    .wr_data (dec.call_ret_pc),
    .rd_idx  (PC_WIDTH'(sp_q) - PC_WIDTH'(1)),
    .rd_data (lifo_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sp_q      <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    lifo_we   = 1'b0;
    // Clear first so a fault raised in the same cycle still sets its flag.
    err_ovf_d = err_clr ? 1'b0 : err_ovf_q;
    err_udf_d = err_clr ? 1'b0 : err_udf_q;
    case (state_q)
      IDLE: begin
        if (dec.call_req) begin
          if (sp_q == SPW'(DEPTH)) begin
            err_ovf_d = 1'b1;
            state_d   = FAULT;
          end else begin
            lifo_we = 1'b1;
            state_d = PUSH;
          end
        end else if (dec.ret_req) begin
          if (sp_q == '0) begin
            err_udf_d = 1'b1;
            state_d   = FAULT;
          end else begin
            state_d = POP_RD;
          end
        end
      end
      PUSH: begin
        sp_d    = sp_q + SPW'(1);
        state_d = IDLE;
      end
      POP_RD:  state_d = POP_WR;
      POP_WR: begin
        sp_d    = sp_q - SPW'(1);
        state_d = IDLE;
      end
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dec.req_ready    = 1'b0;
    dec.done         = 1'b0;
    dec.ret_pc       = '0;
    dec.ret_pc_valid = 1'b0;
    rf_stack_push    = 1'b0;
    rf_stack_pop     = 1'b0;
    rf_stack_pointer = PC_WIDTH'(sp_q);
    case (state_q)
      IDLE: dec.req_ready = 1'b1;
      PUSH: begin
        rf_stack_push    = 1'b1;
        rf_stack_pointer = PC_WIDTH'(sp_q) + PC_WIDTH'(1);
        dec.done         = 1'b1;
      end
      POP_WR: begin
        rf_stack_pop     = 1'b1;
        dec.ret_pc       = lifo_rd_data;
        dec.ret_pc_valid = 1'b1;
        dec.done         = 1'b1;
      end
      FAULT:   dec.done = 1'b1;
      default: ;
    endcase
  end

  assign depth   = sp_q;
  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;

endmodule

// File: tb/tb_rf_ctx_ctrl.sv
// Self-checking bench for rf_ctx_ctrl: directed scenarios plus a randomized
// CALL/RET/clear stream checked against a queue-based return-stack model.
module tb_rf_ctx_ctrl;
  import rf_ctx_pkg::*;

  localparam int PCW = 5;
  localparam int DEP = 4;
  localparam int DW  = $clog2(DEP + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic rf_stack_push, rf_stack_pop, err_ovf, err_udf;
  logic [PCW-1:0] rf_stack_pointer;
  logic [DW-1:0] depth;

  rf_ctx_ctrl_if #(.PC_WIDTH(PCW)) dec_if ();

  rf_ctx_ctrl #(.PC_WIDTH(PCW), .DEPTH(DEP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dec              (dec_if),
    .err_clr          (err_clr),
    .rf_stack_push    (rf_stack_push),
    .rf_stack_pop     (rf_stack_pop),
    .rf_stack_pointer (rf_stack_pointer),
    .depth            (depth),
    .err_ovf          (err_ovf),
    .err_udf          (err_udf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: the return stack as a queue plus the two sticky flags.
  logic [PCW-1:0] model_q[$];
  bit m_ovf = 0;
  bit m_udf = 0;

  // Per-cycle captures of the three cycles following an accept edge.
  logic           c_push [1:3];
  logic           c_pop  [1:3];
  logic           c_done [1:3];
  logic           c_vld  [1:3];
  logic           c_rdy  [1:3];
  logic           c_ovf  [1:3];
  logic           c_udf  [1:3];
  logic [PCW-1:0] c_ptr  [1:3];
  logic [PCW-1:0] c_rpc  [1:3];
  logic [DW-1:0]  c_dep  [1:3];

  task automatic sample(input int k);
    c_push[k] = rf_stack_push;
    c_pop[k]  = rf_stack_pop;
    c_done[k] = dec_if.done;
    c_vld[k]  = dec_if.ret_pc_valid;
    c_rdy[k]  = dec_if.req_ready;
    c_ovf[k]  = err_ovf;
    c_udf[k]  = err_udf;
    c_ptr[k]  = rf_stack_pointer;
    c_rpc[k]  = dec_if.ret_pc;
    c_dep[k]  = depth;
  endtask

  // Present one request in an idle cycle, then capture cycles N+1..N+3.
  task automatic run_op(input bit c, input bit r, input logic [PCW-1:0] pc, input bit clr);
    @(negedge clk);
    dec_if.call_req    = c;
    dec_if.ret_req     = r;
    dec_if.call_ret_pc = pc;
    err_clr            = clr;
    @(posedge clk);
    #1;
    dec_if.call_req = 1'b0;
    dec_if.ret_req  = 1'b0;
    err_clr         = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      sample(k);
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (dec_if.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", dec_if.req_ready); end
    total++; if ({rf_stack_push, rf_stack_pop, dec_if.done, dec_if.ret_pc_valid, err_ovf, err_udf} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=000000", {rf_stack_push, rf_stack_pop, dec_if.done, dec_if.ret_pc_valid, err_ovf, err_udf}); end
    total++; if ({rf_stack_pointer, dec_if.ret_pc, depth} !== '0) begin
      bad++; $display("FAIL reset_values ptr=%0d ret_pc=%0d depth=%0d exp=0", rf_stack_pointer, dec_if.ret_pc, depth); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_call_ret();
    run_op(1'b1, 1'b0, 5'h0C, 1'b0);
    $display("CALL pc=0c push=%b ptr=%0d done=%b depth_after=%0d", c_push[1], c_ptr[1], c_done[1], c_dep[2]);
    total++; if (c_push[1] !== 1'b1) begin bad++; $display("FAIL call_push got=%b exp=1", c_push[1]); end
    total++; if (c_ptr[1] !== 5'd1) begin bad++; $display("FAIL call_ptr got=%0d exp=1", c_ptr[1]); end
    total++; if (c_done[1] !== 1'b1 || c_rdy[1] !== 1'b0) begin bad++; $display("FAIL call_done_ready got=%b%b exp=10", c_done[1], c_rdy[1]); end
    total++; if (c_dep[2] !== 3'd1 || c_rdy[2] !== 1'b1) begin bad++; $display("FAIL call_depth got=%0d ready=%b exp=1/1", c_dep[2], c_rdy[2]); end
    run_op(1'b0, 1'b1, 5'h00, 1'b0);
    $display("RET pop=%b ptr=%0d ret_pc=%h valid=%b depth_after=%0d", c_pop[2], c_ptr[2], c_rpc[2], c_vld[2], c_dep[3]);
    total++; if (c_ptr[1] !== 5'd1 || c_pop[1] !== 1'b0 || c_done[1] !== 1'b0) begin
      bad++; $display("FAIL ret_read ptr=%0d pop=%b done=%b exp=1/0/0", c_ptr[1], c_pop[1], c_done[1]); end
    total++; if (c_pop[2] !== 1'b1 || c_ptr[2] !== 5'd1) begin bad++; $display("FAIL ret_pop pop=%b ptr=%0d exp=1/1", c_pop[2], c_ptr[2]); end
    total++; if (c_rpc[2] !== 5'h0C || c_vld[2] !== 1'b1 || c_done[2] !== 1'b1) begin
      bad++; $display("FAIL ret_pc got=%h valid=%b done=%b exp=0c/1/1", c_rpc[2], c_vld[2], c_done[2]); end
    total++; if (c_rdy[1] !== 1'b0 || c_rdy[2] !== 1'b0 || c_rdy[3] !== 1'b1) begin
      bad++; $display("FAIL ret_ready got=%b%b%b exp=001", c_rdy[1], c_rdy[2], c_rdy[3]); end
    total++; if (c_dep[3] !== 3'd0) begin bad++; $display("FAIL ret_depth got=%0d exp=0", c_dep[3]); end
  endtask

  task automatic test_nested();
    for (int i = 1; i <= 3; i++) run_op(1'b1, 1'b0, PCW'(i), 1'b0);
    for (int i = 3; i >= 1; i--) begin
      run_op(1'b0, 1'b1, 5'h00, 1'b0);
      $display("nested RET ret_pc=%0d ptr=%0d", c_rpc[2], c_ptr[2]);
      total++; if (c_rpc[2] !== PCW'(i) || c_ptr[2] !== PCW'(i) || c_pop[2] !== 1'b1) begin
        bad++; $display("FAIL nested_ret ret_pc=%0d ptr=%0d pop=%b exp=%0d/%0d/1", c_rpc[2], c_ptr[2], c_pop[2], i, i); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEP; i++) run_op(1'b1, 1'b0, PCW'(20 + i), 1'b0);
    // Fifth CALL arrives together with err_clr: the new fault must still win.
    run_op(1'b1, 1'b0, 5'h1F, 1'b1);
    $display("OVF CALL done=%b push=%b err_ovf=%b depth=%0d", c_done[1], c_push[1], c_ovf[1], c_dep[2]);
    total++; if (c_done[1] !== 1'b1 || c_push[1] !== 1'b0) begin bad++; $display("FAIL ovf_done done=%b push=%b exp=1/0", c_done[1], c_push[1]); end
    total++; if (c_ovf[1] !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", c_ovf[1]); end
    total++; if (c_dep[2] !== 3'd4) begin bad++; $display("FAIL ovf_depth got=%0d exp=4", c_dep[2]); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    $display("err_clr err_ovf=%b", err_ovf);
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", err_ovf); end
    for (int i = DEP - 1; i >= 0; i--) begin
      run_op(1'b0, 1'b1, 5'h00, 1'b0);
      total++; if (c_rpc[2] !== PCW'(20 + i)) begin bad++; $display("FAIL ovf_unwind got=%0d exp=%0d", c_rpc[2], 20 + i); end
    end
  endtask

  task automatic test_underflow();
    run_op(1'b0, 1'b1, 5'h00, 1'b0);
    $display("UDF RET done=%b pop=%b valid=%b err_udf=%b", c_done[1], c_pop[1] | c_pop[2], c_vld[1] | c_vld[2], c_udf[1]);
    total++; if (c_done[1] !== 1'b1) begin bad++; $display("FAIL udf_done got=%b exp=1", c_done[1]); end
    total++; if ((c_pop[1] | c_pop[2] | c_vld[1] | c_vld[2]) !== 1'b0) begin bad++; $display("FAIL udf_strobes got=1 exp=0"); end
    total++; if (c_udf[1] !== 1'b1 || c_dep[2] !== 3'd0) begin bad++; $display("FAIL udf_flag got=%b depth=%0d exp=1/0", c_udf[1], c_dep[2]); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    total++; if (err_udf !== 1'b0) begin bad++; $display("FAIL udf_clear got=%b exp=0", err_udf); end
  endtask

  task automatic test_simultaneous();
    run_op(1'b1, 1'b0, 5'h09, 1'b0);
    @(negedge clk);
    dec_if.call_req = 1'b1; dec_if.ret_req = 1'b1; dec_if.call_ret_pc = 5'h11;
    @(posedge clk); #1; dec_if.call_req = 1'b0;
    @(negedge clk); sample(1);
    @(negedge clk); sample(2);
    total++; if (c_push[1] !== 1'b1 || c_pop[1] !== 1'b0) begin bad++; $display("FAIL both_call_first push=%b pop=%b exp=1/0", c_push[1], c_pop[1]); end
    total++; if (c_dep[2] !== 3'd2 || c_rdy[2] !== 1'b1) begin bad++; $display("FAIL both_depth2 got=%0d ready=%b exp=2/1", c_dep[2], c_rdy[2]); end
    @(posedge clk); #1; dec_if.ret_req = 1'b0;
    @(negedge clk); sample(1);
    @(negedge clk); sample(2);
    @(negedge clk); sample(3);
    $display("BOTH then RET ret_pc=%h pop=%b depth=%0d", c_rpc[2], c_pop[2], c_dep[3]);
    total++; if (c_pop[2] !== 1'b1 || c_rpc[2] !== 5'h11) begin bad++; $display("FAIL both_ret pop=%b ret_pc=%h exp=1/11", c_pop[2], c_rpc[2]); end
    total++; if (c_dep[3] !== 3'd1) begin bad++; $display("FAIL both_depth1 got=%0d exp=1", c_dep[3]); end
    run_op(1'b0, 1'b1, 5'h00, 1'b0);
  endtask

  task automatic test_reset_mid_pop();
    int events;
    run_op(1'b0, 1'b1, 5'h00, 1'b0);
    run_op(1'b1, 1'b0, 5'h07, 1'b0);
    @(negedge clk); dec_if.ret_req = 1'b1;
    @(posedge clk); #1; dec_if.ret_req = 1'b0;
    #2; rst_n = 1'b0;
    #1;
    $display("reset in POP_RD ready=%b pop=%b done=%b depth=%0d err_udf=%b", dec_if.req_ready, rf_stack_pop, dec_if.done, depth, err_udf);
    total++; if (dec_if.req_ready !== 1'b1) begin bad++; $display("FAIL rstpop_ready got=%b exp=1", dec_if.req_ready); end
    total++; if ({rf_stack_push, rf_stack_pop, dec_if.done, dec_if.ret_pc_valid, err_ovf, err_udf, rf_stack_pointer, dec_if.ret_pc, depth} !== '0) begin
      bad++; $display("FAIL rstpop_outputs ptr=%0d depth=%0d udf=%b exp=all 0", rf_stack_pointer, depth, err_udf); end
    events = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (rf_stack_pop || dec_if.done) events++;
    end
    total++; if (events !== 0) begin bad++; $display("FAIL rstpop_no_pop got=%0d exp=0", events); end
    total++; if (depth !== '0) begin bad++; $display("FAIL rstpop_depth got=%0d exp=0", depth); end
  endtask

  task automatic test_random();
    int op, sz;
    logic [PCW-1:0] pc, top;
    model_q.delete(); m_ovf = 0; m_udf = 0;
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 9);
      sz = model_q.size();
      if (op == 9) begin
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        m_ovf = 0; m_udf = 0;
        $display("rand %0d CLR ovf=%b udf=%b", n, err_ovf, err_udf);
        total++; if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin bad++; $display("FAIL rand_clr got=%b%b exp=00", err_ovf, err_udf); end
      end else if (op < 5) begin
        pc = PCW'($urandom);
        run_op(1'b1, 1'b0, pc, 1'b0);
        $display("rand %0d CALL pc=%h depth %0d->%0d", n, pc, sz, c_dep[2]);
        if (sz == DEP) begin
          m_ovf = 1;
          total++; if (c_done[1] !== 1'b1 || c_push[1] !== 1'b0 || c_dep[2] !== DW'(sz)) begin
            bad++; $display("FAIL rand_ovf done=%b push=%b depth=%0d exp=1/0/%0d", c_done[1], c_push[1], c_dep[2], sz); end
        end else begin
          model_q.push_back(pc);
          total++; if (c_push[1] !== 1'b1 || c_ptr[1] !== PCW'(sz + 1) || c_done[1] !== 1'b1 || c_dep[2] !== DW'(sz + 1)) begin
            bad++; $display("FAIL rand_call push=%b ptr=%0d done=%b depth=%0d exp=1/%0d/1/%0d", c_push[1], c_ptr[1], c_done[1], c_dep[2], sz + 1, sz + 1); end
        end
      end else begin
        run_op(1'b0, 1'b1, 5'h00, 1'b0);
        $display("rand %0d RET ret_pc=%h valid=%b depth %0d->%0d", n, c_rpc[2], c_vld[2], sz, c_dep[3]);
        if (sz == 0) begin
          m_udf = 1;
          total++; if (c_done[1] !== 1'b1 || (c_pop[1] | c_pop[2] | c_vld[1] | c_vld[2]) !== 1'b0) begin
            bad++; $display("FAIL rand_udf done=%b pop=%b exp=1/0", c_done[1], c_pop[1] | c_pop[2]); end
        end else begin
          top = model_q.pop_back();
          total++; if (c_pop[2] !== 1'b1 || c_ptr[2] !== PCW'(sz) || c_vld[2] !== 1'b1 || c_rpc[2] !== top || c_dep[3] !== DW'(sz - 1)) begin
            bad++; $display("FAIL rand_ret pop=%b ptr=%0d valid=%b ret_pc=%h depth=%0d exp=1/%0d/1/%h/%0d",
                            c_pop[2], c_ptr[2], c_vld[2], c_rpc[2], c_dep[3], sz, top, sz - 1); end
        end
      end
      if (op != 9) begin
        total++; if ((c_push[1] & c_pop[1]) !== 1'b0 && (c_push[2] & c_pop[2]) !== 1'b0) begin bad++; $display("FAIL rand_excl push and pop together"); end
        total++; if (c_ovf[3] !== m_ovf || c_udf[3] !== m_udf) begin
          bad++; $display("FAIL rand_flags got=%b%b exp=%b%b", c_ovf[3], c_udf[3], m_ovf, m_udf); end
      end
    end
  endtask

  initial begin
    dec_if.call_req    = 1'b0;
    dec_if.ret_req     = 1'b0;
    dec_if.call_ret_pc = '0;
    test_reset();
    test_call_ret();
    test_nested();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_reset_mid_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
